// File: rtl/conv_pkg.sv
// Shared convolution datapath constants and helpers, used by the MAC chain and the output stage.
package conv_pkg;

    localparam int unsigned CONV_DATA_WIDTH  = 16;
    localparam int unsigned CONV_SHIFT_WIDTH = 6;

    // Accumulator width for a DW x DW product sum with one guard bit
    function automatic int unsigned acc_width(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

    function automatic logic signed [63:0] sat_max_of(input int unsigned dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min_of(input int unsigned dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    localparam logic signed [CONV_DATA_WIDTH-1:0] CONV_SAT_MAX =
        CONV_DATA_WIDTH'(sat_max_of(CONV_DATA_WIDTH));
    localparam logic signed [CONV_DATA_WIDTH-1:0] CONV_SAT_MIN =
        CONV_DATA_WIDTH'(sat_min_of(CONV_DATA_WIDTH));

endpackage

// File: rtl/conv_output_stage_if.sv
// Accumulator-in / pixel-out stream bundle of the convolution output stage.
interface conv_output_stage_if
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = CONV_DATA_WIDTH,
    parameter int unsigned SHIFT_WIDTH = CONV_SHIFT_WIDTH
);

    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH);

    logic                          in_valid;
    logic signed [ACC_WIDTH-1:0]   in_data;
    logic                          in_ready;
    logic [SHIFT_WIDTH-1:0]        cfg_shift;
    logic                          out_valid;
    logic signed [DATA_WIDTH-1:0]  out_data;
    logic                          out_last;
    logic                          out_ready;
    logic [15:0]                   sat_count;

    // Upstream MAC / downstream consumer side
    modport master (
        output in_valid,
        output in_data,
        output cfg_shift,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  sat_count
    );

    // Output stage side
    modport slave (
        input  in_valid,
        input  in_data,
        input  cfg_shift,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output sat_count
    );

endinterface

// File: rtl/conv_out_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two.
module conv_out_fifo #(
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned WIDTH     = 17,
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;

    // Storage carries no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/conv_output_stage.sv
// Rounding shift, optional ReLU (define CONV_OUT_RELU_EN) and saturation of MAC sums,
// buffered onto a valid/ready pixel stream with frame-end marker and saturation counter.
module conv_output_stage
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = CONV_DATA_WIDTH,
    parameter int unsigned SHIFT_WIDTH  = CONV_SHIFT_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FRAME_PIXELS = 4096
) (
    input  logic               clk,
    input  logic               rst,
    conv_output_stage_if.slave bus
);

    localparam int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH);
    localparam int unsigned EXT_WIDTH  = ACC_WIDTH + 1;
    localparam int unsigned MAX_SHIFT  = 2 * DATA_WIDTH;
    localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_WIDTH  = CNT_WIDTH + 1;
    localparam int unsigned IDX_WIDTH  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int unsigned FIFO_WIDTH = DATA_WIDTH + 1;
    localparam int unsigned UP_WIDTH   = EXT_WIDTH - DATA_WIDTH + 1;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max_of(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min_of(DATA_WIDTH));

    logic                         accept_c;
    logic                         push_c;
    logic                         pop_c;
    logic                         in_ready_q;

    logic [SHIFT_WIDTH-1:0]       shift_c;
    logic signed [EXT_WIDTH-1:0]  bias_c;
    logic signed [EXT_WIDTH-1:0]  ext_sum_c;
    logic signed [EXT_WIDTH-1:0]  s1_data_next_c;
    logic                         s1_valid_q;
    logic signed [EXT_WIDTH-1:0]  s1_data_q;

    logic signed [EXT_WIDTH-1:0]  pre_sat_c;
    logic [UP_WIDTH-1:0]          upper_c;
    logic signed [DATA_WIDTH-1:0] px_c;
    logic                         clamp_c;

    logic [IDX_WIDTH-1:0]         wr_idx_q;
    logic                         last_c;
    logic [15:0]                  sat_count_q;

    logic [CNT_WIDTH-1:0]         fifo_count;
    logic                         fifo_empty;
    logic [FIFO_WIDTH-1:0]        fifo_rdata;
    logic [OCC_WIDTH-1:0]         occ_next_c;

    assign accept_c = bus.in_valid & in_ready_q;
    assign push_c   = s1_valid_q;
    assign pop_c    = ~fifo_empty & bus.out_ready;

    // S1: clamp the shift, add the half-LSB bias in one extra bit, arithmetic shift
    always_comb begin
        shift_c = bus.cfg_shift;
        if (32'(bus.cfg_shift) > 32'(MAX_SHIFT)) begin
            shift_c = SHIFT_WIDTH'(MAX_SHIFT);
        end
        bias_c = '0;
        if (shift_c != '0) begin
            bias_c = EXT_WIDTH'(1) << (shift_c - SHIFT_WIDTH'(1));
        end
        ext_sum_c      = {bus.in_data[ACC_WIDTH-1], bus.in_data} + bias_c;
        s1_data_next_c = ext_sum_c >>> shift_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_data_q <= s1_data_next_c;
            end
        end
    end

    // S2: ReLU, then clamp to the pixel range; in range iff the top bits are a sign run
    always_comb begin
`ifdef CONV_OUT_RELU_EN
        pre_sat_c = s1_data_q[EXT_WIDTH-1] ? '0 : s1_data_q;
`else
        pre_sat_c = s1_data_q;
`endif
        upper_c = pre_sat_c[EXT_WIDTH-1:DATA_WIDTH-1];
        px_c    = pre_sat_c[DATA_WIDTH-1:0];
        clamp_c = 1'b0;
        if (!pre_sat_c[EXT_WIDTH-1] && (|upper_c)) begin
            px_c    = SAT_MAX;
            clamp_c = 1'b1;
        end else if (pre_sat_c[EXT_WIDTH-1] && !(&upper_c)) begin
            px_c    = SAT_MIN;
            clamp_c = 1'b1;
        end
    end

    // Frame position is tracked on the write side; order is preserved so it matches the pop side
    assign last_c = (wr_idx_q == IDX_WIDTH'(FRAME_PIXELS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q    <= '0;
            sat_count_q <= '0;
        end else begin
            if (push_c) begin
                wr_idx_q <= last_c ? '0 : wr_idx_q + IDX_WIDTH'(1);
            end
            if (push_c && clamp_c && (sat_count_q != 16'hFFFF)) begin
                sat_count_q <= sat_count_q + 16'd1;
            end
        end
    end

    conv_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata ({last_c, px_c}),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Credit check counts every beat the stage will hold after this edge
    assign occ_next_c = OCC_WIDTH'(fifo_count) + OCC_WIDTH'(push_c)
                      - OCC_WIDTH'(pop_c) + OCC_WIDTH'(accept_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (occ_next_c < OCC_WIDTH'(FIFO_DEPTH));
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
    assign bus.out_last  = ~fifo_empty & fifo_rdata[DATA_WIDTH];
    assign bus.sat_count = sat_count_q;

endmodule

// File: tb/tb_conv_output_stage.sv
// Directed-vector and stream bench for conv_output_stage (small frame, 4-deep FIFO).
module tb_conv_output_stage;

    localparam int unsigned DW    = 16;
    localparam int unsigned SW    = 6;
    localparam int unsigned DEPTH = 4;
    localparam int          FP    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    conv_output_stage_if #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) bus ();

    conv_output_stage #(
        .DATA_WIDTH   (DW),
        .SHIFT_WIDTH  (SW),
        .FIFO_DEPTH   (DEPTH),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int     sh;
        longint din;
        longint exp_n;
        longint exp_r;
        bit     sat_n;
        bit     sat_r;
    } vec_t;

    int     n_checks  = 0;
    int     n_errors  = 0;
    longint exp_q[$];
    int     n_out     = 0;
    int     n_last    = 0;
    longint sat_model = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pick(input longint no_relu, input longint relu);
`ifdef CONV_OUT_RELU_EN
        return relu;
`else
        return no_relu;
`endif
    endfunction

    // Reference: round half up, shift, optional ReLU, clamp to 16-bit
    function automatic longint model_px(input longint d, input int sh, output bit cl);
        longint v;
        int     s;
        s = (sh > 32) ? 32 : sh;
        v = d;
        if (s > 0) v = v + (longint'(1) <<< (s - 1));
        v = v >>> s;
`ifdef CONV_OUT_RELU_EN
        if (v < 0) v = 0;
`endif
        cl = 1'b0;
        if (v > 32767) begin
            v  = 32767;
            cl = 1'b1;
        end else if (v < -32768) begin
            v  = -32768;
            cl = 1'b1;
        end
        return v;
    endfunction

    task automatic sat_bump();
        if (sat_model < 65535) sat_model++;
    endtask

    task automatic check_head(input longint exp);
        chk("out_data", longint'(bus.out_data), exp);
        chk("out_last", longint'(bus.out_last), ((n_out % FP) == FP - 1) ? 1 : 0);
        if (bus.out_last) n_last++;
        n_out++;
    endtask

    // Single isolated beat: latency, value, last flag, sat counter
    task automatic apply_beat(input int sh, input longint din, input longint exp, input bit sat_inc);
        @(negedge clk);
        chk("in_ready_idle", longint'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 33'(din);
        bus.cfg_shift = 6'(sh);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_shift = ~(6'(sh));
        chk("lat_e0_valid", longint'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_e1_valid", longint'(bus.out_valid), 1);
        if (sat_inc) sat_bump();
        chk("sat_count", longint'(bus.sat_count), sat_model);
        check_head(exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("drained", longint'(bus.out_valid), 0);
    endtask

    // mode 0: random data/shift, 1: ascending sequence, 2: constant saturating value
    task automatic run_stream(input int n, input int mode, input int vpct, input int rpct,
                              input int hold, output int acc_at_hold, output int rdy_at_hold);
        int     sent;
        int     cyc;
        int     budget;
        longint d;
        longint e;
        int     sh;
        bit     cl;
        bit     stalled;
        longint held;
        sent        = 0;
        cyc         = 0;
        budget      = 4 * n + 200;
        acc_at_hold = -1;
        rdy_at_hold = -1;
        stalled     = 1'b0;
        held        = 0;
        d           = 0;
        sh          = 0;
        while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (cyc == hold) begin
                acc_at_hold = sent;
                rdy_at_hold = int'(bus.in_ready);
            end
            if (stalled) begin
                chk("stall_valid", longint'(bus.out_valid), 1);
                chk("stall_data", longint'(bus.out_data), held);
            end
            bus.out_ready = (cyc >= hold) && ($urandom_range(0, 99) < 32'(rpct));
            if (sent < n && $urandom_range(0, 99) < 32'(vpct)) begin
                case (mode)
                    0: begin
                        d  = longint'($urandom_range(0, 200000)) - 100000;
                        sh = int'($urandom_range(0, 6));
                    end
                    1: begin
                        d  = 1000 + 16 * sent;
                        sh = 4;
                    end
                    default: begin
                        d  = 40000;
                        sh = 0;
                    end
                endcase
                bus.in_valid  = 1'b1;
                bus.in_data   = 33'(d);
                bus.cfg_shift = 6'(sh);
            end else begin
                bus.in_valid  = 1'b0;
                bus.cfg_shift = 6'($urandom_range(0, 63));
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = longint'(bus.out_data);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_head(e);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model_px(d, sh, cl);
                exp_q.push_back(e);
                if (cl) sat_bump();
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_complete", longint'(exp_q.size()) + longint'(n - sent), 0);
    endtask

    vec_t tv[14];
    int   acc;
    int   rdy;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_shift = '0;
        bus.out_ready = 1'b0;

        tv[0]  = '{4,  64'sd1000,        63,     63,    1'b0, 1'b0};
        tv[1]  = '{4,  -64'sd1000,       -62,    0,     1'b0, 1'b0};
        tv[2]  = '{0,  64'sd40000,       32767,  32767, 1'b1, 1'b1};
        tv[3]  = '{0,  -64'sd40000,      -32768, 0,     1'b1, 1'b0};
        tv[4]  = '{63, 64'sd4294967295,  1,      1,     1'b0, 1'b0};
        tv[5]  = '{1,  64'sd3,           2,      2,     1'b0, 1'b0};
        tv[6]  = '{1,  -64'sd3,          -1,     0,     1'b0, 1'b0};
        tv[7]  = '{2,  -64'sd6,          -1,     0,     1'b0, 1'b0};
        tv[8]  = '{3,  64'sd100,         13,     13,    1'b0, 1'b0};
        tv[9]  = '{0,  64'sd32767,       32767,  32767, 1'b0, 1'b0};
        tv[10] = '{0,  -64'sd32768,      -32768, 0,     1'b0, 1'b0};
        tv[11] = '{32, -64'sd4294967296, -1,     0,     1'b0, 1'b0};
        tv[12] = '{16, 64'sd4294967295,  32767,  32767, 1'b1, 1'b1};
        tv[13] = '{40, 64'sd2147483648,  1,      1,     1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data",  longint'(bus.out_data),  0);
        chk("rst_out_last",  longint'(bus.out_last),  0);
        chk("rst_in_ready",  longint'(bus.in_ready),  0);
        chk("rst_sat_count", longint'(bus.sat_count), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", longint'(bus.in_ready), 1);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            apply_beat(tv[i].sh, tv[i].din, pick(tv[i].exp_n, tv[i].exp_r),
                       (pick(longint'(tv[i].sat_n), longint'(tv[i].sat_r)) != 0));
        end

        // Backpressure: exactly DEPTH accepts while stalled, then all drain in order
        run_stream(10, 1, 100, 100, 12, acc, rdy);
        chk("bp_accepts", longint'(acc), DEPTH);
        chk("bp_in_ready", longint'(rdy), 0);
        chk("bp_sat_count", longint'(bus.sat_count), sat_model);

        // Reset while the FIFO and S1 hold beats
        acc = 0;
        for (int i = 0; i < 20 && acc < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 33'(500 + i);
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", longint'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_out_data",  longint'(bus.out_data),  0);
        chk("midrst_out_last",  longint'(bus.out_last),  0);
        chk("midrst_in_ready",  longint'(bus.in_ready),  0);
        chk("midrst_sat_count", longint'(bus.sat_count), 0);
        exp_q.delete();
        n_out     = 0;
        n_last    = 0;
        sat_model = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", longint'(bus.in_ready), 1);
        chk("post_rst_empty", longint'(bus.out_valid), 0);

        // Three frames under random valid/ready
        run_stream(3 * FP, 0, 60, 60, 0, acc, rdy);
        chk("frame_beats", longint'(n_out), 3 * FP);
        chk("frame_lasts", longint'(n_last), 3);
        chk("frame_sat_count", longint'(bus.sat_count), sat_model);

        // Saturation counter sticks at all ones
        run_stream(65540, 2, 100, 100, 0, acc, rdy);
        chk("sat_model_sticky", sat_model, 65535);
        chk("sat_count_sticky", longint'(bus.sat_count), 65535);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
